// File: rtl/mem_write_seq.sv
// Memory write sequencer: turns one 8/16-bit store or stack push into one or two
// Z80-style T1/T2/T3 byte write cycles, stretching T2 while mem_wait is high.
module mem_write_seq #(
  parameter logic [15:0] IDLE_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        word_mode,
  input  logic        stack_mode,
  input  logic [15:0] addr_in,
  input  logic [15:0] data_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_dout,
  output logic        mem_wr,
  input  logic        mem_wait
);

  typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

  state_t      state_q, state_d;
  logic        idx_q, idx_d;
  logic        word_q, word_d;
  logic        stack_q, stack_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;

  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [15:0] byte_addr;
  logic [7:0]  byte_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= 1'b0;
      word_q     <= 1'b0;
      stack_q    <= 1'b0;
      addr_q     <= 16'h0000;
      data_q     <= 16'h0000;
      mem_addr_q <= IDLE_ADDR;
      mem_dout_q <= 8'h00;
      mem_wr_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      stack_q    <= stack_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      mem_addr_q <= mem_addr_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Operands are only captured in IDLE, so a start during a write cannot disturb it.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    stack_d = stack_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          word_d  = word_mode;
          stack_d = stack_mode;
          addr_d  = addr_in;
          data_d  = data_in;
          idx_d   = 1'b0;
          state_d = T1;
        end
      end
      T1: state_d = T2;
      T2: begin
        if (!mem_wait) state_d = T3;
      end
      T3: begin
        if (word_q && !idx_q) begin
          idx_d   = 1'b1;
          state_d = T1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from the next state so the registered bus matches the phase it is in.
  always_comb begin
    byte_addr = addr_d;
    byte_data = data_d[7:0];
    if (word_d && !stack_d) begin
      byte_addr = addr_d + {15'h0000, idx_d};
      byte_data = idx_d ? data_d[15:8] : data_d[7:0];
    end else if (word_d && stack_d) begin
      byte_addr = idx_d ? (addr_d - 16'd2) : (addr_d - 16'd1);
      byte_data = idx_d ? data_d[7:0] : data_d[15:8];
    end

    mem_addr_d = (state_d == IDLE) ? IDLE_ADDR : byte_addr;
    mem_dout_d = (state_d == IDLE) ? 8'h00 : byte_data;
    mem_wr_d   = (state_d == T2);
    busy_d     = (state_d != IDLE);
    done_d     = (state_q == T3) && (state_d == IDLE);
  end

  assign mem_addr = mem_addr_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_mem_write_seq.sv
// Bench for mem_write_seq: directed and random stores checked cycle by cycle
// against a timeline model built from the byte list and per-byte wait counts.
module tb_mem_write_seq;

  localparam logic [15:0] IDLE_ADDR = 16'h0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        word_mode;
  logic        stack_mode;
  logic [15:0] addr_in;
  logic [15:0] data_in;
  logic        busy;
  logic        done;
  logic [15:0] mem_addr;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic        mem_wait;

  int compared   = 0;
  int mismatched = 0;

  mem_write_seq #(.IDLE_ADDR(IDLE_ADDR)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .word_mode (word_mode),
    .stack_mode(stack_mode),
    .addr_in   (addr_in),
    .data_in   (data_in),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .mem_wr    (mem_wr),
    .mem_wait  (mem_wait)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; drives start for cycle 0 and checks cycles 1..done.
  // Returns at the negedge of the done cycle so a caller can chain another start.
  task automatic apply_stimulus(input bit wm, input bit sm, input logic [15:0] a,
                                input logic [15:0] d, input int w0, input int w1,
                                input bit poke);
    logic [15:0] ea [2];
    logic [7:0]  ed [2];
    int          w  [2];
    int          s  [2];
    int          n;
    int          dcyc;
    logic        exp_wr, exp_busy, exp_done, hold_wait;
    logic [15:0] exp_addr;
    logic [7:0]  exp_dout;

    n = wm ? 2 : 1;
    ea[1] = 16'h0000;
    ed[1] = 8'h00;
    if (!wm) begin
      ea[0] = a;          ed[0] = d[7:0];
    end else if (!sm) begin
      ea[0] = a;          ed[0] = d[7:0];
      ea[1] = a + 16'd1;  ed[1] = d[15:8];
    end else begin
      ea[0] = a - 16'd1;  ed[0] = d[15:8];
      ea[1] = a - 16'd2;  ed[1] = d[7:0];
    end
    w[0] = w0;
    w[1] = w1;
    s[0] = 1;
    s[1] = s[0] + 3 + w0;
    dcyc = s[n-1] + 3 + w[n-1];

    start      = 1'b1;
    word_mode  = wm;
    stack_mode = sm;
    addr_in    = a;
    data_in    = d;
    mem_wait   = 1'($urandom_range(0, 1));

    for (int c = 1; c <= dcyc; c++) begin
      @(negedge clk);
      exp_wr    = 1'b0;
      exp_busy  = (c < dcyc);
      exp_done  = (c == dcyc);
      exp_addr  = IDLE_ADDR;
      exp_dout  = 8'h00;
      hold_wait = 1'b0;
      for (int b = 0; b < n; b++) begin
        if (c >= s[b] && c <= s[b] + 2 + w[b]) begin
          exp_addr  = ea[b];
          exp_dout  = ed[b];
          exp_wr    = (c > s[b]) && (c <= s[b] + 1 + w[b]);
          hold_wait = (c > s[b]) && (c <= s[b] + w[b]);
        end
      end
      check_output($sformatf("c%0d mem_addr", c), mem_addr, exp_addr);
      check_output($sformatf("c%0d mem_dout", c), {8'h00, mem_dout}, {8'h00, exp_dout});
      check_output($sformatf("c%0d mem_wr", c), {15'h0000, mem_wr}, {15'h0000, exp_wr});
      check_output($sformatf("c%0d busy", c), {15'h0000, busy}, {15'h0000, exp_busy});
      check_output($sformatf("c%0d done", c), {15'h0000, done}, {15'h0000, exp_done});

      start = 1'b0;
      if (poke && c == 2) begin
        start      = 1'b1;
        word_mode  = ~wm;
        stack_mode = ~sm;
        addr_in    = ~a;
        data_in    = ~d;
      end
      mem_wait = exp_wr ? hold_wait : 1'($urandom_range(0, 1));
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check_output({tag, " idle busy"}, {15'h0000, busy}, 16'h0000);
    check_output({tag, " idle done"}, {15'h0000, done}, 16'h0000);
    check_output({tag, " idle mem_wr"}, {15'h0000, mem_wr}, 16'h0000);
    check_output({tag, " idle mem_addr"}, mem_addr, IDLE_ADDR);
    check_output({tag, " idle mem_dout"}, {8'h00, mem_dout}, 16'h0000);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    word_mode  = 1'b0;
    stack_mode = 1'b0;
    addr_in    = 16'h0000;
    data_in    = 16'h0000;
    mem_wait   = 1'b0;

    #2;
    check_output("reset busy", {15'h0000, busy}, 16'h0000);
    check_output("reset done", {15'h0000, done}, 16'h0000);
    check_output("reset mem_wr", {15'h0000, mem_wr}, 16'h0000);
    check_output("reset mem_addr", mem_addr, IDLE_ADDR);
    check_output("reset mem_dout", {8'h00, mem_dout}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] word store, no wait");
    apply_stimulus(1'b1, 1'b0, 16'h1234, 16'hBEEF, 0, 0, 1'b0);
    idle_check("word");

    $display("[TB] push and store across the address wrap");
    apply_stimulus(1'b1, 1'b1, 16'h0001, 16'h1234, 0, 0, 1'b0);
    idle_check("push wrap");
    apply_stimulus(1'b1, 1'b0, 16'hFFFF, 16'hA5C3, 0, 0, 1'b0);
    idle_check("store wrap");

    $display("[TB] byte store with three wait cycles");
    apply_stimulus(1'b0, 1'b0, 16'h8000, 16'hAA55, 3, 0, 1'b0);
    idle_check("byte wait");

    $display("[TB] ignored start while busy, then back-to-back start");
    apply_stimulus(1'b1, 1'b0, 16'h4000, 16'h1357, 1, 2, 1'b1);
    apply_stimulus(1'b1, 1'b1, 16'h2000, 16'h9ABC, 0, 0, 1'b0);
    idle_check("b2b");

    $display("[TB] reset during the second byte's T2");
    start      = 1'b1;
    word_mode  = 1'b1;
    stack_mode = 1'b0;
    addr_in    = 16'h5000;
    data_in    = 16'hCAFE;
    mem_wait   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    mem_wait = 1'b1;
    @(negedge clk);
    check_output("pre-reset mem_wr", {15'h0000, mem_wr}, 16'h0001);
    check_output("pre-reset mem_addr", mem_addr, 16'h5001);
    check_output("pre-reset mem_dout", {8'h00, mem_dout}, 16'h00CA);
    reset = 1'b1;
    #1;
    check_output("async mem_wr", {15'h0000, mem_wr}, 16'h0000);
    check_output("async mem_addr", mem_addr, IDLE_ADDR);
    check_output("async busy", {15'h0000, busy}, 16'h0000);
    check_output("async mem_dout", {8'h00, mem_dout}, 16'h0000);
    @(negedge clk);
    reset    = 1'b0;
    mem_wait = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output($sformatf("post-reset done %0d", i), {15'h0000, done}, 16'h0000);
      check_output($sformatf("post-reset busy %0d", i), {15'h0000, busy}, 16'h0000);
    end
    apply_stimulus(1'b1, 1'b0, 16'h6000, 16'h0F1E, 1, 1, 1'b0);
    idle_check("after reset");

    $display("[TB] random stores");
    for (int i = 0; i < 30; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     16'($urandom), 16'($urandom),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 0) idle_check($sformatf("rand %0d", i));
    end
    idle_check("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
